// File: rtl/pkt_buf_ctrl_if.sv
// Ingress stream and core data-memory port of the packet buffer controller.
// The producer side (network ingress plus core load/store) uses master;
// the buffer controller uses slave.
interface pkt_buf_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic [ADDR_W-1:0] cpu_mem_addr_i;
  logic [DATA_W-1:0] cpu_mem_din_i;
  logic              cpu_mem_wena_i;
  logic [DATA_W-1:0] data_mem_out_o;

  modport master (
    output in_valid, in_data, in_last, cpu_mem_addr_i, cpu_mem_din_i, cpu_mem_wena_i,
    input  in_ready, data_mem_out_o
  );

  modport slave (
    input  in_valid, in_data, in_last, cpu_mem_addr_i, cpu_mem_din_i, cpu_mem_wena_i,
    output in_ready, data_mem_out_o
  );
endinterface

// File: rtl/pkt_buf_ctrl.sv
// Packet buffer controller: ingress writes packet words into a shared
// dual-port buffer, cores load/store through port B, and a small FSM offers
// one complete packet at a time and releases it once every core reports done.
// Optional macro PKT_BUF_DROP_EN adds a drop verdict and a drop counter.
module pkt_buf_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 64,
  parameter int NCORES   = 2,
  parameter int MAX_PKTS = 4
) (
  input  logic              clk,
  input  logic              rst,
  pkt_buf_ctrl_if.slave     bus,
  output logic [ADDR_W-1:0] w_ptr,
  output logic [ADDR_W-1:0] r_ptr,
  output logic [ADDR_W-1:0] w_ptr_prev,
  output logic              p_en,
  output logic [7:0]        count,
  input  logic [NCORES-1:0] pi_di,
  input  logic              match_i,
  output logic              all_proc_done,
  output logic              pkt_drop_o
);
  localparam int                DEPTH     = 1 << ADDR_W;
  localparam int                BF_W      = (MAX_PKTS > 1) ? $clog2(MAX_PKTS) : 1;
  localparam logic [7:0]        MAX_CNT   = 8'(MAX_PKTS);
  localparam logic [ADDR_W-1:0] FULL_USED = '1;

  typedef enum logic [1:0] {IDLE, OFFER, RELEASE} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic [ADDR_W-1:0] bfifo [MAX_PKTS];
  logic [BF_W-1:0]   bf_wr, bf_rd;
  logic [ADDR_W-1:0] used;
  logic              in_rdy, acc, push, pop, bf_full;

  // one slot stays empty so w_ptr == r_ptr always means "buffer empty"
  assign used    = w_ptr - r_ptr;
  assign bf_full = (count == MAX_CNT);
  assign in_rdy  = (used != FULL_USED) & ~bf_full;
  assign acc     = bus.in_valid & in_rdy;
  assign push    = acc & bus.in_last;
  assign pop     = (state == RELEASE);

  assign bus.in_ready       = in_rdy;
  assign bus.data_mem_out_o = rd_q;

  // buffer writes: a core store colliding with the ingress write is dropped
  always_ff @(posedge clk) begin
    if (bus.cpu_mem_wena_i && !(acc && (bus.cpu_mem_addr_i == w_ptr)))
      mem[bus.cpu_mem_addr_i] <= bus.cpu_mem_din_i;
    if (acc)
      mem[w_ptr] <= bus.in_data;
  end

  // registered, read-first core load port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_q <= '0;
    else      rd_q <= mem[bus.cpu_mem_addr_i];
  end

  // boundary FIFO storage: exclusive end address of each complete packet
  always_ff @(posedge clk) begin
    if (push) bfifo[bf_wr] <= w_ptr + 1'b1;
  end

  // pointers, packet count and FIFO indices
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_ptr      <= '0;
      r_ptr      <= '0;
      w_ptr_prev <= '0;
      count      <= '0;
      bf_wr      <= '0;
      bf_rd      <= '0;
    end else begin
      if (acc)  w_ptr <= w_ptr + 1'b1;
      if (push) bf_wr <= bf_wr + 1'b1;
      if (pop) begin
        r_ptr <= w_ptr_prev;
        bf_rd <= bf_rd + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 8'd1;
        2'b01:   count <= count - 8'd1;
        default: count <= count;
      endcase
      if ((state == IDLE) && (state_nxt == OFFER))
        w_ptr_prev <= bfifo[bf_rd];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next state and offer/release outputs
  always_comb begin
    state_nxt     = state;
    p_en          = 1'b0;
    all_proc_done = 1'b0;
    case (state)
      IDLE:    if (count != 8'd0) state_nxt = OFFER;
      OFFER: begin
        p_en = 1'b1;
        if (&pi_di) state_nxt = RELEASE;
      end
      RELEASE: begin
        all_proc_done = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PKT_BUF_DROP_EN
  logic [15:0] drop_cnt;
  assign pkt_drop_o = all_proc_done & match_i;

  // saturating count of dropped packets
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  drop_cnt <= '0;
    else if (pkt_drop_o && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`else
  logic unused_match;
  assign unused_match = match_i;
  assign pkt_drop_o   = 1'b0;
`endif
endmodule

// File: tb/tb_pkt_buf_ctrl.sv
// Directed bench for pkt_buf_ctrl: a per-cycle vector table for the basic
// packet/offer/release and core-port behaviour, then hand-written sequences
// for buffer-full stall, reset mid-operation and boundary-FIFO full.
module tb_pkt_buf_ctrl;
  localparam int AW = 8;
  localparam int DW = 64;
`ifdef PKT_BUF_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pkt_buf_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  logic [AW-1:0] w_ptr, r_ptr, w_ptr_prev;
  logic          p_en, all_proc_done, pkt_drop_o, match_i;
  logic [7:0]    count;
  logic [1:0]    pi_di;

  pkt_buf_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NCORES(2), .MAX_PKTS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .w_ptr(w_ptr), .r_ptr(r_ptr), .w_ptr_prev(w_ptr_prev),
    .p_en(p_en), .count(count), .pi_di(pi_di), .match_i(match_i),
    .all_proc_done(all_proc_done), .pkt_drop_o(pkt_drop_o)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic v, last; logic [63:0] d; logic [7:0] a; logic we; logic [63:0] din;
    logic [1:0] pi; logic m;
    logic [7:0] e_w, e_r, e_wp, e_cnt; logic e_pen, e_done, e_rdy, e_drop;
    logic cd; logic [63:0] e_dout;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic last, logic [63:0] d, logic [7:0] a, logic we,
                              logic [63:0] din, logic [1:0] pi, logic m,
                              logic [7:0] w, logic [7:0] r, logic [7:0] wp, logic [7:0] cnt,
                              logic pen, logic done, logic rdy, logic drop,
                              logic cd, logic [63:0] dout);
    vec_t t;
    t.v = v; t.last = last; t.d = d; t.a = a; t.we = we; t.din = din; t.pi = pi; t.m = m;
    t.e_w = w; t.e_r = r; t.e_wp = wp; t.e_cnt = cnt;
    t.e_pen = pen; t.e_done = done; t.e_rdy = rdy; t.e_drop = drop;
    t.cd = cd; t.e_dout = dout;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // waits (bounded) for a release pulse, sampling on falling edges
  task automatic wait_done(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!all_proc_done && n < 20);
    checks++;
    if (!all_proc_done) begin
      errors++;
      $display("FAIL %s: no all_proc_done within %0d cycles", name, n);
    end
  endtask

  task automatic reset_state_checks(input string tag);
    chk({tag, " w_ptr"}, w_ptr, 0);
    chk({tag, " r_ptr"}, r_ptr, 0);
    chk({tag, " w_ptr_prev"}, w_ptr_prev, 0);
    chk({tag, " count"}, count, 0);
    chk({tag, " p_en"}, p_en, 0);
    chk({tag, " all_proc_done"}, all_proc_done, 0);
    chk({tag, " pkt_drop_o"}, pkt_drop_o, 0);
    chk({tag, " in_ready"}, bus.in_ready, 1);
    chk({tag, " data_mem_out_o"}, bus.data_mem_out_o, 0);
  endtask

  initial begin
    int n;
    bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0;
    bus.cpu_mem_addr_i = '0; bus.cpu_mem_din_i = '0; bus.cpu_mem_wena_i = 0;
    pi_di = 2'b00; match_i = 0;

    // v l  d              a  we din            pi     m  | w  r  wp cnt pen dn rdy drop cd dout
    tbl.push_back(mk(1,0,64'hA0, 0,0,0,            2'b00,0, 1,0,0,0, 0,0,1,0, 0,0));
    tbl.push_back(mk(1,0,64'hA1, 0,0,0,            2'b00,0, 2,0,0,0, 0,0,1,0, 0,0));
    tbl.push_back(mk(1,1,64'hA2, 0,0,0,            2'b00,0, 3,0,0,1, 0,0,1,0, 0,0));
    tbl.push_back(mk(0,0,0,      1,0,0,            2'b01,0, 3,0,3,1, 1,0,1,0, 1,64'hA1));
    tbl.push_back(mk(0,0,0,      2,0,0,            2'b01,0, 3,0,3,1, 1,0,1,0, 1,64'hA2));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0,0,0,    0,0,0,            2'b01,0, 3,0,3,1, 1,0,1,0, 0,0));
    tbl.push_back(mk(0,0,0,      0,0,0,            2'b11,0, 3,0,3,1, 0,1,1,0, 0,0));
    tbl.push_back(mk(0,0,0,      0,0,0,            2'b11,0, 3,3,3,0, 0,0,1,0, 0,0));
    tbl.push_back(mk(0,0,0,      0,0,0,            2'b11,0, 3,3,3,0, 0,0,1,0, 0,0));
    tbl.push_back(mk(0,0,0,      5,1,64'hDEAD,     2'b00,0, 3,3,3,0, 0,0,1,0, 0,0));
    tbl.push_back(mk(0,0,0,      5,0,0,            2'b00,0, 3,3,3,0, 0,0,1,0, 1,64'hDEAD));
    tbl.push_back(mk(0,0,0,      5,1,64'hBEEF,     2'b00,0, 3,3,3,0, 0,0,1,0, 1,64'hDEAD));
    tbl.push_back(mk(0,0,0,      5,0,0,            2'b00,0, 3,3,3,0, 0,0,1,0, 1,64'hBEEF));
    tbl.push_back(mk(1,0,64'hB3, 0,0,0,            2'b00,0, 4,3,3,0, 0,0,1,0, 0,0));
    tbl.push_back(mk(1,0,64'hB4, 0,0,0,            2'b00,0, 5,3,3,0, 0,0,1,0, 0,0));
    tbl.push_back(mk(1,1,64'hB5, 5,1,64'hC0DE,     2'b00,0, 6,3,3,1, 0,0,1,0, 1,64'hBEEF));
    tbl.push_back(mk(0,0,0,      5,0,0,            2'b00,1, 6,3,6,1, 1,0,1,0, 1,64'hB5));
    tbl.push_back(mk(0,0,0,      0,0,0,            2'b11,1, 6,3,6,1, 0,1,1,DROP, 0,0));
    tbl.push_back(mk(0,0,0,      3,0,0,            2'b00,0, 6,6,6,0, 0,0,1,0, 1,64'hB3));

    // reset state, released on a falling edge
    repeat (2) @(negedge clk);
    reset_state_checks("reset");
    rst = 1'b1;

    foreach (tbl[i]) begin
      bus.in_valid = tbl[i].v; bus.in_last = tbl[i].last; bus.in_data = tbl[i].d;
      bus.cpu_mem_addr_i = tbl[i].a; bus.cpu_mem_wena_i = tbl[i].we;
      bus.cpu_mem_din_i = tbl[i].din; pi_di = tbl[i].pi; match_i = tbl[i].m;
      tick();
      chk($sformatf("row%0d w_ptr", i), w_ptr, tbl[i].e_w);
      chk($sformatf("row%0d r_ptr", i), r_ptr, tbl[i].e_r);
      chk($sformatf("row%0d w_ptr_prev", i), w_ptr_prev, tbl[i].e_wp);
      chk($sformatf("row%0d count", i), count, tbl[i].e_cnt);
      chk($sformatf("row%0d p_en", i), p_en, tbl[i].e_pen);
      chk($sformatf("row%0d all_proc_done", i), all_proc_done, tbl[i].e_done);
      chk($sformatf("row%0d in_ready", i), bus.in_ready, tbl[i].e_rdy);
      chk($sformatf("row%0d pkt_drop_o", i), pkt_drop_o, tbl[i].e_drop);
      if (tbl[i].cd) chk($sformatf("row%0d data_mem_out_o", i), bus.data_mem_out_o, tbl[i].e_dout);
    end
    bus.cpu_mem_wena_i = 0; pi_di = 2'b00; match_i = 0;
`ifdef PKT_BUF_DROP_EN
    chk("drop_cnt", dut.drop_cnt, 1);
`endif

    // fill the buffer: one-word packet at addr 6, then 254 words of an open packet
    for (int i = 0; i < 255; i++) begin
      bus.in_valid = 1; bus.in_last = (i == 0); bus.in_data = 64'h5000 + 64'(i);
      tick();
    end
    bus.in_last = 0;
    chk("full in_ready", bus.in_ready, 0);
    chk("full w_ptr wrap", w_ptr, 5);
    chk("full count", count, 1);
    chk("full p_en", p_en, 1);
    tick();
    chk("stalled w_ptr", w_ptr, 5);
    bus.in_valid = 0; pi_di = 2'b11;
    wait_done("full release", n);
    chk("release-cycle in_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("post-release r_ptr", r_ptr, 7);
    chk("post-release in_ready", bus.in_ready, 1);
    chk("post-release count", count, 0);
    pi_di = 2'b00;

    // reset mid-operation: immediate clear, buffer contents kept
    tick();
    #2 rst = 1'b0;
    #1 reset_state_checks("midreset");
    @(negedge clk);
    rst = 1'b1;
    bus.cpu_mem_addr_i = 8'd6;
    tick();
    chk("buffer kept over reset", bus.data_mem_out_o, 64'h5000);

    // boundary FIFO full with 4 one-word packets
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1; bus.in_last = 1; bus.in_data = 64'h70 + 64'(i);
      tick();
    end
    chk("bfifo full count", count, 4);
    chk("bfifo full in_ready", bus.in_ready, 0);
    chk("bfifo full w_ptr", w_ptr, 4);
    tick();
    chk("blocked push w_ptr", w_ptr, 4);
    chk("blocked push count", count, 4);
    bus.in_valid = 0; pi_di = 2'b11;
    wait_done("bfifo release 1", n);
    @(negedge clk);
    chk("after pop count", count, 3);
    chk("after pop r_ptr", r_ptr, 1);
    chk("after pop in_ready", bus.in_ready, 1);
    wait_done("bfifo release 2", n);
    chk("release gap", n, 2);
    bus.in_valid = 1; bus.in_last = 1; bus.in_data = 64'h99;
    tick();
    bus.in_valid = 0; bus.in_last = 0; pi_di = 2'b00;
    chk("push+pop count", count, 3);
    chk("push+pop w_ptr", w_ptr, 5);
    chk("push+pop r_ptr", r_ptr, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pkt_buf_ctrl.md
# pkt_buf_ctrl

Packet buffer controller: the responder side of the RISC-V cores' external data-memory and polling interface. It accepts 64-bit packet words from the network ingress stream into a 256x64 shared buffer and serves core load/store traffic to that buffer. It drives the polling values `w_ptr`, `r_ptr`, `w_ptr_prev`, `p_en` and `count` to the cores, collects each core's `pi_di`, and issues `all_proc_done` to release a processed packet.

## Interface

Parameters:
- `ADDR_W`, 8: buffer address width; depth is 2^ADDR_W words.
- `DATA_W`, 64: word width.
- `NCORES`, 2: number of cores reporting `pi_di`.
- `MAX_PKTS`, 4: depth of the packet-boundary FIFO (power of 2).

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous active-low reset.
- `in_valid`, in, 1: ingress word valid.
- `in_data`, in, DATA_W: ingress word.
- `in_last`, in, 1: marks the final word of a packet.
- `in_ready`, out, 1: ingress can accept a word.
- `cpu_mem_addr_i`, in, ADDR_W: core buffer address.
- `cpu_mem_din_i`, in, DATA_W: core store data.
- `cpu_mem_wena_i`, in, 1: core store enable.
- `data_mem_out_o`, out, DATA_W: core load data.
- `w_ptr`, out, ADDR_W: next ingress write address.
- `r_ptr`, out, ADDR_W: start of the oldest unreleased packet.
- `w_ptr_prev`, out, ADDR_W: exclusive end of the offered packet.
- `p_en`, out, 1: a packet is offered for processing.
- `count`, out, 8: complete packets held and not yet released.
- `pi_di`, in, NCORES: per-core "all threads processed".
- `match_i`, in, 1: OR of the cores' XOR-match flags.
- `all_proc_done`, out, 1: one-cycle release pulse.
- `pkt_drop_o`, out, 1: one-cycle drop verdict, coincident with `all_proc_done`.

## Operation

Buffer storage and ports:
- Dual-port RAM of 2^ADDR_W x DATA_W.
- Port A: ingress write only.
- Port B: core read/write.

Ingress:
- A word is accepted when `in_valid & in_ready`. It is written to `w_ptr`, then `w_ptr` is incremented modulo 2^ADDR_W.
- `in_ready` = (used < 2^ADDR_W-1) & ~bfifo_full.
  - used = (w_ptr - r_ptr) mod 2^ADDR_W.
  - One slot is always kept empty.
- An accepted word with `in_last` pushes the post-increment `w_ptr` into the boundary FIFO and increments `count`.
- Every packet is at least 1 word long.

Core port:
- Registered read: `addr` at cycle N gives `data_mem_out_o` at N+1.
- Read-first: a same-cycle store to the same address returns the old data.
- Same-address writes on port A and port B in the same cycle: the ingress write wins and the core store is dropped.

State machine:
- IDLE: `p_en`=0. Go to OFFER when `count`≠0.
  - Entry into OFFER loads `w_ptr_prev` from the boundary FIFO head.
- OFFER: `p_en`=1. Go to RELEASE when `&pi_di`.
- RELEASE (one cycle):
  - `all_proc_done`=1.
  - `r_ptr` <= `w_ptr_prev`.
  - Pop the boundary FIFO and decrement `count`.
  - Return to IDLE.

Boundary conditions:
- A push and a pop in the same cycle leave `count` unchanged.
- `w_ptr`, `r_ptr` and `w_ptr_prev` wrap 255→0 without special handling.
- A packet that fills the buffer mid-stream stalls ingress (`in_ready`=0) until a release frees space.
- `pi_di` held high through IDLE does not re-trigger a release until the next OFFER.

## Timing

Reset values (all outputs):
- `w_ptr`, `r_ptr`, `w_ptr_prev`, `count` = 0.
- `p_en`, `all_proc_done`, `pkt_drop_o` = 0.
- `in_ready` = 1.
- `data_mem_out_o` = 0.
- State = IDLE.
- Boundary FIFO empty.

Latencies:
- `count` and `w_ptr` update on the clock edge that accepts the word.
- `p_en` rises 1 cycle after `count` becomes nonzero.
- `all_proc_done` is asserted the cycle after `&pi_di` is sampled in OFFER.
- `r_ptr` and `count` update on the edge that ends RELEASE.
- The minimum gap between two releases is 3 cycles.

Reset mid-operation clears all state immediately. Buffer contents are not cleared.

## Configuration

Macro `PKT_BUF_DROP_EN`:
- Defined:
  - `match_i` is sampled in RELEASE and `pkt_drop_o` = `match_i` for that cycle.
  - An internal 16-bit saturating `drop_cnt` increments on each drop.
- Undefined:
  - `match_i` is ignored.
  - `pkt_drop_o` is tied to 0.
  - No `drop_cnt` is present.

## Test plan

- Reset, then push a 3-word packet (last on word 3):
  - `w_ptr`=3, `count`=1.
  - `p_en`=1 one cycle later.
  - `w_ptr_prev`=3, `r_ptr`=0.
- OFFER with `pi_di`=2'b01 for 10 cycles, then 2'b11:
  - No release during the 10 cycles.
  - Then a single `all_proc_done` pulse.
  - `r_ptr`=3, `count`=0, `p_en`=0.
- Core store 0xDEAD to address 5 at cycle N, then load address 5 at N+1:
  - `data_mem_out_o`=0xDEAD at N+2.
  - Same-cycle ingress and core write to address 5: ingress data is retained.
- Stream 255 words with no release:
  - `in_ready` drops after used=255.
  - It rises the cycle after the first release.
  - `w_ptr` wraps to 0 correctly.
- Push 4 one-word packets (MAX_PKTS=4):
  - `in_ready`=0 with `count`=4.
  - A simultaneous `in_last` push and release keeps `count` unchanged.
- With `PKT_BUF_DROP_EN`, `match_i`=1 at release:
  - `pkt_drop_o`=1 coincident with `all_proc_done`.
  - `drop_cnt`=1.
  - Without the macro, `pkt_drop_o` stays 0.
